memory_address_selector: RTL and testbench

- Registered 4:1 selector choosing one of four candidate memory addresses (zero/one/two/three) by a 2-bit select code.
- Sits in the datapath ahead of the memory address port. The control unit drives the select. Sources include PC, ALU result, stack pointer and immediate.
- One-cycle latency. The output holds its value between loads.

---
 rtl/memory_address_selector_pkg.sv | 11 +
 rtl/memory_address_selector_mux4.sv | 26 ++
 rtl/memory_address_selector.sv | 53 +++++
 tb/tb_memory_address_selector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_address_selector_pkg.sv
// Shared select-code constants and default width for the memory address selector.
package memory_address_selector_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 16;

    localparam logic [1:0] SEL_ZERO  = 2'd0;
    localparam logic [1:0] SEL_ONE   = 2'd1;
    localparam logic [1:0] SEL_TWO   = 2'd2;
    localparam logic [1:0] SEL_THREE = 2'd3;

endpackage : memory_address_selector_pkg

// File: rtl/memory_address_selector_mux4.sv
// Combinational WIDTH-bit 4:1 mux; only the selected input reaches the output.
module memory_address_selector_mux4
    import memory_address_selector_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_zero,
    input  logic [WIDTH-1:0] i_one,
    input  logic [WIDTH-1:0] i_two,
    input  logic [WIDTH-1:0] i_three,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_zero;
        case (i_sel)
            SEL_ZERO:  o_data = i_zero;
            SEL_ONE:   o_data = i_one;
            SEL_TWO:   o_data = i_two;
            SEL_THREE: o_data = i_three;
            default:   o_data = i_zero;
        endcase
    end

endmodule : memory_address_selector_mux4

// File: rtl/memory_address_selector.sv
// Registered 4:1 memory address selector with load enable, valid flag and select echo.
module memory_address_selector
    import memory_address_selector_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       m_addr,
    input  logic [WIDTH-1:0] three,
    input  logic [WIDTH-1:0] two,
    input  logic [WIDTH-1:0] one,
    input  logic [WIDTH-1:0] zero,
    output logic [WIDTH-1:0] addr_out,
    output logic             addr_valid,
    output logic [1:0]       sel_out
);

    logic [WIDTH-1:0] w_mux_data;
    logic [WIDTH-1:0] r_addr;
    logic [1:0]       r_sel;
    logic             r_valid;

    memory_address_selector_mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .i_sel   (m_addr),
        .i_zero  (zero),
        .i_one   (one),
        .i_two   (two),
        .i_three (three),
        .o_data  (w_mux_data)
    );

    // Reset wins over en; without en every register simply holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_sel   <= SEL_ZERO;
            r_valid <= 1'b0;
        end else if (en) begin
            r_addr  <= w_mux_data;
            r_sel   <= m_addr;
            r_valid <= 1'b1;
        end
    end

    assign addr_out   = r_addr;
    assign sel_out    = r_sel;
    assign addr_valid = r_valid;

endmodule : memory_address_selector

// File: tb/tb_memory_address_selector.sv
// Directed self-checking bench for memory_address_selector.
module tb_memory_address_selector;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       m_addr;
    logic [WIDTH-1:0] three;
    logic [WIDTH-1:0] two;
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] zero;
    logic [WIDTH-1:0] addr_out;
    logic             addr_valid;
    logic [1:0]       sel_out;

    int checks;
    int failures;

    memory_address_selector #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .m_addr     (m_addr),
        .three      (three),
        .two        (two),
        .one        (one),
        .zero       (zero),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .sel_out    (sel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; m_addr = 2'd3; three = 16'h0003;
        tick();
        tick();
        checks++;
        if (addr_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", addr_out, 16'h0000);
        end
        checks++;
        if (sel_out !== 2'd0) begin
            failures++;
            $display("FAIL reset_sel got=%0d exp=0", sel_out);
        end
        checks++;
        if (addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", addr_valid);
        end
        $display("reset: addr=%h sel=%0d valid=%b", addr_out, sel_out, addr_valid);
    endtask

    task automatic test_sweep();
        reset = 1'b0; en = 1'b1;
        zero = 16'd0; one = 16'd1; two = 16'd2; three = 16'd3;
        for (int i = 0; i < 4; i++) begin
            m_addr = 2'(i);
            tick();
            checks++;
            if (addr_out !== 16'(i)) begin
                failures++;
                $display("FAIL sweep_addr code=%0d got=%h exp=%h", i, addr_out, 16'(i));
            end
            checks++;
            if (sel_out !== 2'(i)) begin
                failures++;
                $display("FAIL sweep_sel code=%0d got=%0d exp=%0d", i, sel_out, i);
            end
            checks++;
            if (addr_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_valid code=%0d got=%b exp=1", i, addr_valid);
            end
            $display("sweep: code=%0d addr=%h sel=%0d valid=%b", i, addr_out, sel_out, addr_valid);
        end
    endtask

    task automatic test_patterns();
        logic [WIDTH-1:0] exp_pat [4];
        exp_pat[0] = 16'hA000; exp_pat[1] = 16'h0B00;
        exp_pat[2] = 16'h00C0; exp_pat[3] = 16'h000D;
        zero = 16'hA000; one = 16'h0B00; two = 16'h00C0; three = 16'h000D;
        en = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            m_addr = 2'(i);
            tick();
            checks++;
            if (addr_out !== exp_pat[i]) begin
                failures++;
                $display("FAIL pattern_addr code=%0d got=%h exp=%h", i, addr_out, exp_pat[i]);
            end
            checks++;
            if (sel_out !== 2'(i)) begin
                failures++;
                $display("FAIL pattern_sel code=%0d got=%0d exp=%0d", i, sel_out, i);
            end
            $display("pattern: code=%0d addr=%h sel=%0d", i, addr_out, sel_out);
        end
    endtask

    task automatic test_hold();
        en = 1'b1; m_addr = 2'd2; two = 16'h1234;
        tick();
        checks++;
        if (addr_out !== 16'h1234) begin
            failures++;
            $display("FAIL hold_load got=%h exp=1234", addr_out);
        end
        en = 1'b0; m_addr = 2'd1; two = 16'hFFFF;
        tick();
        tick();
        checks++;
        if (addr_out !== 16'h1234) begin
            failures++;
            $display("FAIL hold_addr got=%h exp=1234", addr_out);
        end
        checks++;
        if (sel_out !== 2'd2) begin
            failures++;
            $display("FAIL hold_sel got=%0d exp=2", sel_out);
        end
        checks++;
        if (addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_valid got=%b exp=1", addr_valid);
        end
        $display("hold: addr=%h sel=%0d valid=%b", addr_out, sel_out, addr_valid);
    endtask

    task automatic test_midstream_reset();
        en = 1'b1; m_addr = 2'd3; three = 16'h000D; one = 16'h0B00;
        tick();
        checks++;
        if (addr_out !== 16'h000D) begin
            failures++;
            $display("FAIL mid_load got=%h exp=000d", addr_out);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (addr_out !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset_addr got=%h exp=0000", addr_out);
        end
        checks++;
        if (addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_valid got=%b exp=0", addr_valid);
        end
        checks++;
        if (sel_out !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_sel got=%0d exp=0", sel_out);
        end
        reset = 1'b0; m_addr = 2'd1;
        tick();
        checks++;
        if (addr_out !== 16'h0B00) begin
            failures++;
            $display("FAIL post_reset_load got=%h exp=0b00", addr_out);
        end
        checks++;
        if (addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_valid got=%b exp=1", addr_valid);
        end
        $display("midreset: addr=%h sel=%0d valid=%b", addr_out, sel_out, addr_valid);
    endtask

    task automatic test_between_edges();
        en = 1'b1; m_addr = 2'd0; zero = 16'h1111; two = 16'h2222; three = 16'h3333;
        tick();
        #1 m_addr = 2'd3;
        #1 m_addr = 2'd2;
        #1;
        checks++;
        if (addr_out !== 16'h1111) begin
            failures++;
            $display("FAIL between_hold got=%h exp=1111", addr_out);
        end
        tick();
        checks++;
        if (addr_out !== 16'h2222) begin
            failures++;
            $display("FAIL between_next got=%h exp=2222", addr_out);
        end
        checks++;
        if (sel_out !== 2'd2) begin
            failures++;
            $display("FAIL between_sel got=%0d exp=2", sel_out);
        end
        $display("between: addr=%h sel=%0d", addr_out, sel_out);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; en = 1'b0; m_addr = 2'd0;
        zero = '0; one = '0; two = '0; three = '0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_patterns();
        test_hold();
        test_midstream_reset();
        test_between_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memory_address_selector
